// File: rtl/loader_defs_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM encoding,
// byte-group sizes and datapath widths.
package loader_defs;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DATA_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned BCNT_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_SUM  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // States in which the loader consumes stream bytes
    function automatic logic is_loading(input state_e s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_SUM);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word assembler: shifts bytes in and pulses word_valid_c
// together with the completed word on the last byte of each group.
module byte_assembler
    import loader_defs::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_c,
    output logic [DATA_W-1:0] word_c
);

    localparam int unsigned SH_W = (WORD_BYTES - 1) * BYTE_W;

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]   sh_q,  sh_d;
    logic              last_c;

    assign last_c       = (cnt_q == BCNT_W'(WORD_BYTES - 1));
    assign word_valid_c = byte_en_i && !clr_i && last_c;
    // Oldest byte has drifted down to bits [7:0]; the live byte lands on top
    assign word_c       = {byte_i, sh_q};

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (byte_en_i) begin
            cnt_d = cnt_q + BCNT_W'(1);
            sh_d  = {byte_i, sh_q[SH_W-1:BYTE_W]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction-memory loader: parses a word-count header, writes the
// payload words and holds the core in reset until the load completes.
// Optional trailing checksum word is enabled with `define LOADER_CHECKSUM_EN.
module program_loader
    import loader_defs::*;
#(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [31:0]       words_loaded
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e ST_AFTER_DATA = ST_SUM;
`else
    localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

    state_e state_q, state_d;

    logic              accept_c;
    logic              word_valid_c;
    logic [DATA_W-1:0] word_c;
    logic              last_word_c;

    logic [DATA_W-1:0] n_q,     n_d;
    logic [DATA_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] words_q, words_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q,   sum_d;
`endif

    logic              in_ready_q,   in_ready_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              core_rst_q,   core_rst_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;

    // A reload cycle never consumes a byte, even if the source is presenting one
    assign in_ready    = in_ready_q && !reload;
    assign accept_c    = in_valid && in_ready;
    assign last_word_c = ((words_q + DATA_W'(1)) == n_q);

    byte_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (reload),
        .byte_en_i    (accept_c),
        .byte_i       (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_HDR;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = ST_HDR;
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (word_valid_c) begin
                        if (word_c == '0)                          state_d = ST_AFTER_DATA;
                        else if (word_c > DATA_W'(MAX_WORDS))      state_d = ST_ERR;
                        else                                       state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (word_valid_c && last_word_c) state_d = ST_AFTER_DATA;
                end
`ifdef LOADER_CHECKSUM_EN
                ST_SUM: begin
                    if (word_valid_c) state_d = (word_c == sum_q) ? ST_DONE : ST_ERR;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        n_d          = n_q;
        addr_d       = addr_q;
        words_d      = words_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        in_ready_d   = is_loading(state_d);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
        // Core leaves reset only one cycle after DONE is entered
        core_rst_d   = reload || (state_q != ST_DONE);

        if (reload) begin
            addr_d  = DATA_W'(BASE_ADDR);
            words_d = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else if (word_valid_c) begin
            case (state_q)
                ST_HDR: begin
                    n_d     = word_c;
                    addr_d  = DATA_W'(BASE_ADDR);
                    words_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
                ST_DATA: begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ADDR_W'(addr_q);
                    imem_wdata_d = word_c;
                    addr_d       = addr_q + DATA_W'(WORD_BYTES);
                    words_d      = words_q + DATA_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = sum_q + word_c;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q          <= '0;
            addr_q       <= DATA_W'(BASE_ADDR);
            words_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= ADDR_W'(BASE_ADDR);
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            n_q          <= n_d;
            addr_q       <= addr_d;
            words_q      <= words_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_rst     = core_rst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (BASE_ADDR 0, MAX_WORDS 4).
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;
    logic [31:0] words_loaded;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          cyc          = 0;
    int          last_we_cyc  = -1;
    int          fall_cyc     = -1;
    logic        core_rst_prv = 1'b1;

    always #5 clk = ~clk;

    program_loader #(
        .BASE_ADDR (0),
        .MAX_WORDS (4),
        .ADDR_W    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // Write/reset monitor, sampling pre-edge values
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (core_rst_prv === 1'b1 && core_rst === 1'b0) fall_cyc = cyc;
        core_rst_prv = core_rst;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rdy_on_byte", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_reload(input logic with_byte, input logic [7:0] b);
        @(negedge clk);
        reload   = 1'b1;
        in_valid = with_byte;
        in_data  = b;
        #1;
        check_eq("rdy_in_reload", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reload   = 1'b0;
        in_valid = 1'b0;
        check_eq("reload_core_rst", 32'(core_rst), 32'd1);
        check_eq("reload_words", words_loaded, 32'd0);
        check_eq("reload_done", 32'(done), 32'd0);
        check_eq("reload_err", 32'(err), 32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        idle(3);

        // Reset values
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_imem_we", 32'(imem_we), 32'd0);
        check_eq("rst_imem_addr", imem_addr, 32'h0);
        check_eq("rst_imem_wdata", imem_wdata, 32'h0);
        check_eq("rst_core_rst", 32'(core_rst), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_words", words_loaded, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rdy_after_rst", 32'(in_ready), 32'd1);

        // Two-word load directly after reset
        send_word(32'h0000_0002);
        send_word(32'h0010_0013);
        check_eq("t2_words_mid", words_loaded, 32'd1);
        send_word(32'h0000_006F);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0010_0082);
`else
        check_eq("t2_we_at_done", 32'(imem_we), 32'd1);
`endif
        check_eq("t2_done", 32'(done), 32'd1);
        check_eq("t2_core_rst_held", 32'(core_rst), 32'd1);
        idle(4);
        check_eq("t2_nwr", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check_eq("t2_addr0", wr_addr_q[0], 32'h0);
            check_eq("t2_data0", wr_data_q[0], 32'h0010_0013);
            check_eq("t2_addr1", wr_addr_q[1], 32'h4);
            check_eq("t2_data1", wr_data_q[1], 32'h0000_006F);
        end
        check_eq("t2_words", words_loaded, 32'd2);
        check_eq("t2_core_rst", 32'(core_rst), 32'd0);
        check_eq("t2_in_ready", 32'(in_ready), 32'd0);
        check_eq("t2_err", 32'(err), 32'd0);
`ifndef LOADER_CHECKSUM_EN
        check_eq("t2_rst_fall", 32'(fall_cyc), 32'(last_we_cyc + 1));
`endif

        // Zero-length load
        pulse_reload(1'b0, 8'h00);
        send_word(32'h0);
`ifdef LOADER_CHECKSUM_EN
        check_eq("t3_done_before_sum", 32'(done), 32'd0);
        send_word(32'h0);
`endif
        check_eq("t3_done", 32'(done), 32'd1);
        idle(3);
        check_eq("t3_nwr", 32'(wr_addr_q.size()), 32'd0);
        check_eq("t3_core_rst", 32'(core_rst), 32'd0);

        // Oversize header (5 > MAX_WORDS)
        pulse_reload(1'b0, 8'h00);
        send_word(32'h0000_0005);
        check_eq("t4_err", 32'(err), 32'd1);
        check_eq("t4_in_ready", 32'(in_ready), 32'd0);
        check_eq("t4_done", 32'(done), 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        idle(4);
        in_valid = 1'b0;
        check_eq("t4_err_hold", 32'(err), 32'd1);
        check_eq("t4_core_rst", 32'(core_rst), 32'd1);
        check_eq("t4_words", words_loaded, 32'd0);
        check_eq("t4_nwr", 32'(wr_addr_q.size()), 32'd0);

        // in_valid gaps across one word
        pulse_reload(1'b0, 8'h00);
        send_word(32'h0000_0001);
        a = 32'hDDCC_BBAA;
        for (int i = 0; i < 4; i++) begin
            send_byte(a[8*i +: 8]);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("t5_we", 32'(imem_we), 32'd1);
        check_eq("t5_wdata", imem_wdata, 32'hDDCC_BBAA);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hDDCC_BBAA);
`endif
        idle(3);
        check_eq("t5_nwr", 32'(wr_addr_q.size()), 32'd1);
        check_eq("t5_words", words_loaded, 32'd1);
        check_eq("t5_done", 32'(done), 32'd1);

        // Reload after 1.5 words of a 3-word load, byte offered in reload cycle
        pulse_reload(1'b0, 8'h00);
        send_word(32'h0000_0003);
        send_word(32'h4433_2211);
        send_byte(8'h55);
        send_byte(8'h66);
        check_eq("t6_words_pre", words_loaded, 32'd1);
        pulse_reload(1'b1, 8'h99);
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h1234_5678);
`endif
        idle(3);
        check_eq("t6_nwr", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check_eq("t6_addr", wr_addr_q[0], 32'h0);
            check_eq("t6_data", wr_data_q[0], 32'h1234_5678);
        end
        check_eq("t6_words", words_loaded, 32'd1);
        check_eq("t6_done", 32'(done), 32'd1);
        check_eq("t6_err", 32'(err), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: words land, load rejected
        pulse_reload(1'b0, 8'h00);
        send_word(32'h0000_0002);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_word(32'h0000_0004);
        check_eq("t7_err", 32'(err), 32'd1);
        idle(3);
        check_eq("t7_nwr", 32'(wr_addr_q.size()), 32'd2);
        check_eq("t7_done", 32'(done), 32'd0);
        check_eq("t7_core_rst", 32'(core_rst), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
